// File: rtl/pc_sequencer.sv
// pc_sequencer: per-thread PCs and run/halt states, round-robin issue to fetch with trap > redirect > increment priority
module pc_sequencer #(
    parameter int XLEN = 32,
    parameter int NUM_THREADS = 2,
    parameter int INST_BYTES = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100),
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   stall_i,
    input  logic                   redirect_valid_i,
    input  logic [TID_W-1:0]       redirect_tid_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    input  logic                   trap_valid_i,
    input  logic [TID_W-1:0]       trap_tid_i,
    input  logic                   halt_valid_i,
    input  logic [TID_W-1:0]       halt_tid_i,
    input  logic                   resume_valid_i,
    input  logic [TID_W-1:0]       resume_tid_i,
    output logic                   fetch_valid_o,
    output logic [XLEN-1:0]        fetch_pc_o,
    output logic [TID_W-1:0]       fetch_tid_o,
    output logic [NUM_THREADS-1:0] halted_mask_o,
    output logic                   all_halted_o
);
    typedef enum logic {RUN, HALTED} state_e;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
    logic [XLEN-1:0] pc_q [NUM_THREADS];
    logic [XLEN-1:0] pc_d [NUM_THREADS];
    state_e st_q [NUM_THREADS];
    state_e st_d [NUM_THREADS];
    logic [TID_W-1:0] last_q, sel_tid, cand;
    logic sel_found;
    // scan starts just after the last issuer so every running thread gets a turn
    always_comb begin
        sel_found = 1'b0;
        sel_tid = last_q;
        cand = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            cand = TID_W'((int'(last_q) + i) % NUM_THREADS);
            if (!sel_found && st_q[cand] == RUN) begin
                sel_found = 1'b1;
                sel_tid = cand;
            end
        end
    end
    assign fetch_valid_o = !reset_i && !stall_i && sel_found;
    assign fetch_tid_o = sel_tid;
    assign fetch_pc_o = pc_q[sel_tid];
    assign all_halted_o = &halted_mask_o;
    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
        logic trap_hit, redir_hit, issue_hit, halt_hit, resume_hit;
        assign trap_hit = trap_valid_i && trap_tid_i == TID_W'(g);
        assign redir_hit = redirect_valid_i && redirect_tid_i == TID_W'(g);
        assign issue_hit = fetch_valid_o && sel_tid == TID_W'(g);
        assign halt_hit = halt_valid_i && halt_tid_i == TID_W'(g);
        assign resume_hit = resume_valid_i && resume_tid_i == TID_W'(g);
        assign pc_d[g] = trap_hit ? TRAP_VECTOR :
                         redir_hit ? (redirect_pc_i & ALIGN_MASK) :
                         issue_hit ? pc_q[g] + XLEN'(INST_BYTES) : pc_q[g];
        assign st_d[g] = halt_hit ? HALTED : resume_hit ? RUN : st_q[g];
        assign halted_mask_o[g] = st_q[g] == HALTED;
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= '{default: RESET_VECTOR};
            st_q <= '{default: RUN};
            last_q <= TID_W'(NUM_THREADS - 1);
        end else begin
            pc_q <= pc_d;
            st_q <= st_d;
            if (fetch_valid_o) last_q <= sel_tid;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table, randomized model comparison, and an 8-bit/3-thread instance for wrap and tid range
module tb_pc_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stall, rv, rt, tv, tt, hv, ht, sv, stt;
    logic [31:0] rpc;
    logic fv, ft, ah;
    logic [31:0] fpc;
    logic [1:0] hm;

    logic b_reset, b_stall, b_rv, b_tv, b_hv, b_sv;
    logic [1:0] b_rt, b_tt, b_ht, b_st;
    logic [7:0] b_rpc;
    logic b_fv, b_ah;
    logic [1:0] b_ft;
    logic [7:0] b_fpc;
    logic [2:0] b_hm;

    int checks = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall),
        .redirect_valid_i(rv), .redirect_tid_i(rt), .redirect_pc_i(rpc),
        .trap_valid_i(tv), .trap_tid_i(tt),
        .halt_valid_i(hv), .halt_tid_i(ht),
        .resume_valid_i(sv), .resume_tid_i(stt),
        .fetch_valid_o(fv), .fetch_pc_o(fpc), .fetch_tid_o(ft),
        .halted_mask_o(hm), .all_halted_o(ah)
    );

    pc_sequencer #(.XLEN(8), .NUM_THREADS(3)) dut8 (
        .clk_i(clk), .reset_i(b_reset), .stall_i(b_stall),
        .redirect_valid_i(b_rv), .redirect_tid_i(b_rt), .redirect_pc_i(b_rpc),
        .trap_valid_i(b_tv), .trap_tid_i(b_tt),
        .halt_valid_i(b_hv), .halt_tid_i(b_ht),
        .resume_valid_i(b_sv), .resume_tid_i(b_st),
        .fetch_valid_o(b_fv), .fetch_pc_o(b_fpc), .fetch_tid_o(b_ft),
        .halted_mask_o(b_hm), .all_halted_o(b_ah)
    );

    typedef struct {
        logic rst, st, rv, rt;
        logic [31:0] rpc;
        logic tv, tt, hv, ht, sv, stt;
        logic efv, eft;
        logic [31:0] efpc;
        logic cm;
        logic [1:0] em;
    } vec_t;
    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_issue(input string name, input logic [1:0] et, input logic [7:0] ep);
        #3;
        chk({name, "_fv"}, 32'(b_fv), 32'd1);
        chk({name, "_tid"}, 32'(b_ft), 32'(et));
        chk({name, "_pc"}, 32'(b_fpc), 32'(ep));
        tick();
    endtask

    logic [31:0] mpc [2];
    bit mh [2];
    int mlast, et;
    bit efv, primed;

    initial begin
        // fields: rst st rv rt rpc tv tt hv ht sv stt | fv tid pc chk_mask mask
        tbl[0]  = '{1,0,0,0,0,      0,0,0,0,0,0, 0,0,0,        0,0};
        tbl[1]  = '{0,0,0,0,0,      0,0,0,0,0,0, 1,0,0,        1,0};
        tbl[2]  = '{0,0,0,0,0,      0,0,0,0,0,0, 1,1,0,        1,0};
        tbl[3]  = '{0,0,0,0,0,      0,0,0,0,0,0, 1,0,4,        1,0};
        tbl[4]  = '{0,0,0,0,0,      0,0,0,0,0,0, 1,1,4,        1,0};
        tbl[5]  = '{0,1,0,0,0,      0,0,0,0,0,0, 0,0,0,        1,0};
        tbl[6]  = '{0,1,0,0,0,      0,0,0,0,0,0, 0,0,0,        1,0};
        tbl[7]  = '{0,1,0,0,0,      0,0,0,0,0,0, 0,0,0,        1,0};
        tbl[8]  = '{0,0,0,0,0,      0,0,0,0,0,0, 1,0,8,        1,0};
        tbl[9]  = '{0,0,1,1,'h203,  1,1,0,0,0,0, 1,1,8,        1,0};
        tbl[10] = '{0,0,1,0,'h203,  0,0,0,0,0,0, 1,0,'hC,      1,0};
        tbl[11] = '{0,0,0,0,0,      0,0,0,0,0,0, 1,1,'h100,    1,0};
        tbl[12] = '{0,0,0,0,0,      0,0,0,0,0,0, 1,0,'h200,    1,0};
        tbl[13] = '{0,0,0,0,0,      0,0,1,0,0,0, 1,1,'h104,    1,0};
        tbl[14] = '{0,0,0,0,0,      0,0,0,0,0,0, 1,1,'h108,    1,1};
        tbl[15] = '{0,0,0,0,0,      0,0,1,1,1,1, 1,1,'h10C,    1,1};
        tbl[16] = '{0,0,0,0,0,      1,1,0,0,0,0, 0,0,0,        1,3};
        tbl[17] = '{0,0,0,0,0,      0,0,0,0,1,0, 0,0,0,        1,3};
        tbl[18] = '{0,0,0,0,0,      0,0,0,0,1,1, 1,0,'h204,    1,2};
        tbl[19] = '{0,0,0,0,0,      0,0,0,0,0,0, 1,1,'h100,    1,0};
        tbl[20] = '{1,0,1,0,'h300,  0,0,1,0,0,0, 0,0,0,        1,0};
        tbl[21] = '{0,0,0,0,0,      0,0,0,0,0,0, 1,0,0,        1,0};
        tbl[22] = '{0,0,0,0,0,      0,0,0,0,0,0, 1,1,0,        1,0};

        {b_stall, b_rv, b_tv, b_hv, b_sv} = '0;
        {b_rt, b_tt, b_ht, b_st, b_rpc} = '0;
        b_reset = 1'b1;

        for (int i = 0; i < 23; i++) begin
            reset = tbl[i].rst; stall = tbl[i].st; rv = tbl[i].rv; rt = tbl[i].rt;
            rpc = tbl[i].rpc; tv = tbl[i].tv; tt = tbl[i].tt; hv = tbl[i].hv;
            ht = tbl[i].ht; sv = tbl[i].sv; stt = tbl[i].stt;
            #3;
            chk($sformatf("row%0d_fv", i), 32'(fv), 32'(tbl[i].efv));
            if (tbl[i].efv) begin
                chk($sformatf("row%0d_tid", i), 32'(ft), 32'(tbl[i].eft));
                chk($sformatf("row%0d_pc", i), fpc, tbl[i].efpc);
            end
            if (tbl[i].cm) begin
                chk($sformatf("row%0d_mask", i), 32'(hm), 32'(tbl[i].em));
                chk($sformatf("row%0d_allh", i), 32'(ah), 32'(&tbl[i].em));
            end
            @(posedge clk);
            #1;
        end

        primed = 0;
        mlast = 1;
        for (int c = 0; c < 400; c++) begin
            reset = (c == 0) || ($urandom_range(99) < 3);
            stall = $urandom_range(99) < 25;
            rv = $urandom_range(99) < 20; rt = 1'($urandom); rpc = $urandom;
            tv = $urandom_range(99) < 10; tt = 1'($urandom);
            hv = $urandom_range(99) < 12; ht = 1'($urandom);
            sv = $urandom_range(99) < 25; stt = 1'($urandom);
            if (c > 0 && c % 97 == 0) rpc = 32'hFFFF_FFFF;
            #3;
            efv = 0;
            et = 0;
            for (int k = 1; k <= 2; k++)
                if (!efv && !mh[(mlast + k) % 2]) begin
                    efv = 1;
                    et = (mlast + k) % 2;
                end
            efv = efv && !reset && !stall && primed;
            if (primed) begin
                chk("rand_fv", 32'(fv), 32'(efv && !reset));
                chk("rand_mask", 32'(hm), {30'd0, mh[1], mh[0]});
                if (efv) begin
                    chk("rand_tid", 32'(ft), 32'(et));
                    chk("rand_pc", fpc, mpc[et]);
                end
            end
            @(posedge clk);
            #1;
            if (reset) begin
                mpc[0] = 0; mpc[1] = 0; mh[0] = 0; mh[1] = 0; mlast = 1;
                primed = 1;
            end else begin
                for (int t = 0; t < 2; t++)
                    if (tv && int'(tt) == t) mpc[t] = 32'h100;
                    else if (rv && int'(rt) == t) mpc[t] = {rpc[31:2], 2'b00};
                    else if (efv && et == t) mpc[t] = mpc[t] + 4;
                if (sv) mh[stt] = 0;
                if (hv) mh[ht] = 1;
                if (efv) mlast = et;
            end
        end
        reset = 1'b1;

        #3;
        chk("b_reset_fv", 32'(b_fv), 32'd0);
        tick();
        b_reset = 1'b0;
        b_rv = 1; b_rt = 0; b_rpc = 8'hFF;
        b_hv = 1; b_ht = 3; b_tv = 1; b_tt = 3;
        b_issue("b_a", 0, 8'h00);
        {b_rv, b_hv, b_tv} = '0;
        #3;
        chk("b_mask_oor", 32'(b_hm), 32'd0);
        #0 b_issue("b_b", 1, 8'h00);
        b_issue("b_c", 2, 8'h00);
        b_issue("b_d", 0, 8'hFC);
        b_hv = 1; b_ht = 2;
        b_issue("b_e", 1, 8'h04);
        b_hv = 0;
        #3;
        chk("b_mask_h2", 32'(b_hm), 32'd4);
        chk("b_allh", 32'(b_ah), 32'd0);
        #0 b_issue("b_f_wrap", 0, 8'h00);
        b_issue("b_g", 1, 8'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
